move_tiros_multi: RTL and testbench

//  Parametrised successor of the single-shot mover: stores up to N_TIROS shots (x, y, direction, active bit)
//  and, on each iniciar request from the game control unit, advances every active shot one step along its

---
 rtl/asteroids_pkg.sv | 42 ++++
 rtl/move_tiros_multi_tiro_passo.sv | 49 ++++
 rtl/move_tiros_multi.sv | 146 ++++++++++++++
 tb/tb_move_tiros_multi.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Shared constants for the shot mover: direction codes,
// debug state codes and edge-handling modes.
package asteroids_pkg;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  localparam logic [4:0] ST_ESPERA    = 5'd0;
  localparam logic [4:0] ST_CARREGA   = 5'd1;
  localparam logic [4:0] ST_ATUALIZA  = 5'd2;
  localparam logic [4:0] ST_CONCLUIDO = 5'd3;

  localparam int BORDA_DESATIVA = 0;
  localparam int BORDA_CONTORNA = 1;

  function automatic logic signed [1:0] passo_x(
    input logic [2:0] d
  );
    unique case (d)
      DIR_NE, DIR_E, DIR_SE: return 2'sd1;
      DIR_SW, DIR_W, DIR_NW: return -2'sd1;
      default:               return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] passo_y(
    input logic [2:0] d
  );
    unique case (d)
      DIR_SE, DIR_S, DIR_SW: return 2'sd1;
      DIR_NW, DIR_N, DIR_NE: return -2'sd1;
      default:               return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/move_tiros_multi_tiro_passo.sv
// One movement step of a shot: {x,y,dir} -> next position.
// Ports: x,y,dir in; x_novo,y_novo,saiu (left screen) out.
module tiro_passo
  import asteroids_pkg::*;
#(
  parameter int COORD_W    = 4,
  parameter int LIMITE_X   = 15,
  parameter int LIMITE_Y   = 15,
  parameter int MODO_BORDA = BORDA_DESATIVA
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [2:0]         dir,
  output logic [COORD_W-1:0] x_novo,
  output logic [COORD_W-1:0] y_novo,
  output logic               saiu
);

  // Two guard bits so LIMITE+1 never aliases to a negative value.
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] LX = SW'(LIMITE_X);
  localparam logic signed [SW-1:0] LY = SW'(LIMITE_Y);
  localparam logic [COORD_W-1:0] LXC = COORD_W'(LIMITE_X);
  localparam logic [COORD_W-1:0] LYC = COORD_W'(LIMITE_Y);

  logic signed [1:0]    dx, dy;
  logic signed [SW-1:0] nx, ny;
  logic                 fora_x, fora_y;

  always_comb begin
    dx = passo_x(dir);
    dy = passo_y(dir);
    nx = $signed({2'b00, x}) + {{(SW-2){dx[1]}}, dx};
    ny = $signed({2'b00, y}) + {{(SW-2){dy[1]}}, dy};
    fora_x = nx[SW-1] || (nx > LX);
    fora_y = ny[SW-1] || (ny > LY);
    saiu   = fora_x || fora_y;
    x_novo = nx[COORD_W-1:0];
    y_novo = ny[COORD_W-1:0];
    if (MODO_BORDA == BORDA_CONTORNA) begin
      if (fora_x) x_novo = nx[SW-1] ? LXC : '0;
      if (fora_y) y_novo = ny[SW-1] ? LYC : '0;
    end else if (saiu) begin
      x_novo = x;
      y_novo = y;
    end
  end

endmodule

// File: rtl/move_tiros_multi.sv
// Multi-slot shot store: spawns shots and steps all of them.
// Ports: clock/reset, iniciar/novo_* in; read port, status out.
module move_tiros_multi
  import asteroids_pkg::*;
#(
  parameter int N_TIROS    = 4,
  parameter int COORD_W    = 4,
  parameter int LIMITE_X   = 15,
  parameter int LIMITE_Y   = 15,
  parameter int MODO_BORDA = BORDA_DESATIVA,
  localparam int IDX_W     = $clog2(N_TIROS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               novo_tiro,
  input  logic [COORD_W-1:0] novo_x,
  input  logic [COORD_W-1:0] novo_y,
  input  logic [2:0]         nova_direcao,
  input  logic [IDX_W-1:0]   sel_tiro,
  output logic [COORD_W-1:0] tiro_x,
  output logic [COORD_W-1:0] tiro_y,
  output logic [2:0]         tiro_direcao,
  output logic               tiro_ativo,
  output logic [N_TIROS-1:0] tiros_ativos,
  output logic               pronto,
  output logic               movimentacao_concluida_tiro,
  output logic               tiro_descartado,
  output logic [4:0]         db_estado
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_TIROS - 1);

  logic [COORD_W-1:0] px [N_TIROS];
  logic [COORD_W-1:0] py [N_TIROS];
  logic [2:0]         pd [N_TIROS];
  logic [N_TIROS-1:0] ativo;

  logic [4:0]         estado;
  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] wx, wy;
  logic [2:0]         wd;
  logic               wa;

  logic [COORD_W-1:0] x_novo, y_novo;
  logic               saiu;
  logic [IDX_W-1:0]   livre;
  logic               tem_livre;
  logic               spawn;

  tiro_passo #(
    .COORD_W   (COORD_W),
    .LIMITE_X  (LIMITE_X),
    .LIMITE_Y  (LIMITE_Y),
    .MODO_BORDA(MODO_BORDA)
  ) u_passo (
    .x     (wx),
    .y     (wy),
    .dir   (wd),
    .x_novo(x_novo),
    .y_novo(y_novo),
    .saiu  (saiu)
  );

  // Lowest-index inactive slot wins.
  always_comb begin
    livre     = '0;
    tem_livre = 1'b0;
    for (int i = N_TIROS - 1; i >= 0; i--) begin
      if (!ativo[i]) begin
        livre     = IDX_W'(i);
        tem_livre = 1'b1;
      end
    end
  end

  assign spawn = (estado == ST_ESPERA) && novo_tiro && !iniciar;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= ST_ESPERA;
      idx             <= '0;
      wx              <= '0;
      wy              <= '0;
      wd              <= '0;
      wa              <= 1'b0;
      tiro_descartado <= 1'b0;
    end else begin
      tiro_descartado <= spawn && !tem_livre;
      case (estado)
        ST_ESPERA: begin
          if (iniciar) begin
            estado <= ST_CARREGA;
            idx    <= '0;
          end
        end
        ST_CARREGA: begin
          wx     <= px[idx];
          wy     <= py[idx];
          wd     <= pd[idx];
          wa     <= ativo[idx];
          estado <= ST_ATUALIZA;
        end
        ST_ATUALIZA: begin
          if (idx == IDX_MAX) begin
            estado <= ST_CONCLUIDO;
          end else begin
            idx    <= idx + 1'b1;
            estado <= ST_CARREGA;
          end
        end
        default: estado <= ST_ESPERA;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TIROS; i++) begin
        px[i] <= '0;
        py[i] <= '0;
        pd[i] <= '0;
      end
      ativo <= '0;
    end else if (spawn && tem_livre) begin
      px[livre]    <= novo_x;
      py[livre]    <= novo_y;
      pd[livre]    <= nova_direcao;
      ativo[livre] <= 1'b1;
    end else if (estado == ST_ATUALIZA && wa) begin
      px[idx]    <= x_novo;
      py[idx]    <= y_novo;
      ativo[idx] <= (MODO_BORDA == BORDA_CONTORNA) || !saiu;
    end
  end

  assign tiro_x       = px[sel_tiro];
  assign tiro_y       = py[sel_tiro];
  assign tiro_direcao = pd[sel_tiro];
  assign tiro_ativo   = ativo[sel_tiro];
  assign tiros_ativos = ativo;
  assign pronto       = (estado == ST_ESPERA);
  assign db_estado    = estado;
  assign movimentacao_concluida_tiro = (estado == ST_CONCLUIDO);

endmodule

// File: tb/tb_move_tiros_multi.sv
// Bench for move_tiros_multi: despawn and wrap instances
// driven in lockstep, checked against a queued model.
module tb_move_tiros_multi;

  typedef struct packed {
    logic [3:0]      a;
    logic [3:0][2:0] d;
    logic [3:0][3:0] y;
    logic [3:0][3:0] x;
  } snap_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       novo_tiro = 1'b0;
  logic [3:0] novo_x = '0;
  logic [3:0] novo_y = '0;
  logic [2:0] nova_direcao = '0;
  logic [1:0] sel = '0;

  logic [3:0] x0, y0, x1, y1, ta0, ta1;
  logic [2:0] d0, d1;
  logic       a0, a1, pr0, pr1, cc0, cc1, td0, td1;
  logic [4:0] db0, db1;

  int mx [2][4];
  int my [2][4];
  int md [2][4];
  bit ma [2][4];
  snap_t q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  move_tiros_multi #(.MODO_BORDA(0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .novo_tiro(novo_tiro), .novo_x(novo_x),
    .novo_y(novo_y), .nova_direcao(nova_direcao),
    .sel_tiro(sel), .tiro_x(x0), .tiro_y(y0),
    .tiro_direcao(d0), .tiro_ativo(a0),
    .tiros_ativos(ta0), .pronto(pr0),
    .movimentacao_concluida_tiro(cc0),
    .tiro_descartado(td0), .db_estado(db0)
  );

  move_tiros_multi #(.MODO_BORDA(1)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .novo_tiro(novo_tiro), .novo_x(novo_x),
    .novo_y(novo_y), .nova_direcao(nova_direcao),
    .sel_tiro(sel), .tiro_x(x1), .tiro_y(y1),
    .tiro_direcao(d1), .tiro_ativo(a1),
    .tiros_ativos(ta1), .pronto(pr1),
    .movimentacao_concluida_tiro(cc1),
    .tiro_descartado(td1), .db_estado(db1)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 4; s++) begin
        mx[d][s] = 0; my[d][s] = 0;
        md[d][s] = 0; ma[d][s] = 0;
      end
  endtask

  function automatic snap_t mk_snap(int d);
    snap_t r;
    for (int s = 0; s < 4; s++) begin
      r.x[s] = 4'(mx[d][s]);
      r.y[s] = 4'(my[d][s]);
      r.d[s] = 3'(md[d][s]);
      r.a[s] = ma[d][s];
    end
    return r;
  endfunction

  task automatic model_step(int d);
    int dx, dy, nx, ny;
    for (int s = 0; s < 4; s++) begin
      if (ma[d][s]) begin
        dx = 0; dy = 0;
        case (md[d][s])
          0: dy = -1;
          1: begin dx = 1;  dy = -1; end
          2: dx = 1;
          3: begin dx = 1;  dy = 1;  end
          4: dy = 1;
          5: begin dx = -1; dy = 1;  end
          6: dx = -1;
          default: begin dx = -1; dy = -1; end
        endcase
        nx = mx[d][s] + dx;
        ny = my[d][s] + dy;
        if (d == 0) begin
          if (nx < 0 || nx > 15 || ny < 0 || ny > 15)
            ma[d][s] = 0;
          else begin
            mx[d][s] = nx; my[d][s] = ny;
          end
        end else begin
          if (nx < 0) nx = 15;
          else if (nx > 15) nx = 0;
          if (ny < 0) ny = 15;
          else if (ny > 15) ny = 0;
          mx[d][s] = nx; my[d][s] = ny;
        end
      end
    end
  endtask

  task automatic check_dut(int d, snap_t e);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("x%0d_d%0d", s, d),
          32'(d == 0 ? x0 : x1), 32'(e.x[s]));
      chk($sformatf("y%0d_d%0d", s, d),
          32'(d == 0 ? y0 : y1), 32'(e.y[s]));
      chk($sformatf("dir%0d_d%0d", s, d),
          32'(d == 0 ? d0 : d1), 32'(e.d[s]));
      chk($sformatf("act%0d_d%0d", s, d),
          32'(d == 0 ? a0 : a1), 32'(e.a[s]));
    end
    chk($sformatf("ativos_d%0d", d),
        32'(d == 0 ? ta0 : ta1), 32'(e.a));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_ta0"}, 32'(ta0), 0);
    chk({tag, "_ta1"}, 32'(ta1), 0);
    chk({tag, "_pronto"}, 32'(pr0), 1);
    chk({tag, "_db"}, 32'(db0), 0);
    chk({tag, "_conc"}, 32'(cc0), 0);
    chk({tag, "_desc"}, 32'(td0), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    tick();
    check_reset_vals("rst");
    reset = 1'b1;
    tick();
  endtask

  task automatic spawn(int x, int y, int dir);
    bit full [2];
    for (int d = 0; d < 2; d++) begin
      full[d] = 1;
      for (int s = 0; s < 4; s++) begin
        if (full[d] && !ma[d][s]) begin
          full[d] = 0;
          mx[d][s] = x; my[d][s] = y;
          md[d][s] = dir; ma[d][s] = 1;
        end
      end
    end
    novo_x = 4'(x);
    novo_y = 4'(y);
    nova_direcao = 3'(dir);
    novo_tiro = 1'b1;
    tick();
    novo_tiro = 1'b0;
    chk("desc_d0", 32'(td0), 32'(full[0]));
    chk("desc_d1", 32'(td1), 32'(full[1]));
  endtask

  task automatic run_pass(bit hold_novo);
    int n;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      q.push_back(mk_snap(d));
    end
    iniciar = 1'b1;
    novo_tiro = hold_novo;
    tick();
    iniciar = 1'b0;
    n = 1;
    chk("db_carrega", 32'(db0), 1);
    while (!cc0 && n < 40) begin
      tick();
      n++;
    end
    novo_tiro = 1'b0;
    chk("latency", 32'(n), 9);
    chk("conc_d1", 32'(cc1), 1);
    chk("db_concl", 32'(db0), 3);
    tick();
    chk("pulse_len", 32'(cc0), 0);
    chk("pronto_after", 32'(pr0), 1);
    chk("desc_pass", 32'(td0), 0);
    for (int d = 0; d < 2; d++) begin
      if (q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        check_dut(d, q.pop_front());
      end
    end
  endtask

  initial begin
    bit seen;
    model_clear();

    // 1: empty pass, fixed latency
    do_reset();
    run_pass(1'b0);

    // 2: despawn on edge (d0) vs wrap (d1)
    do_reset();
    spawn(5, 5, 2);
    spawn(5, 5, 0);
    spawn(0, 0, 7);
    run_pass(1'b0);

    // 3: corner and side wrap
    do_reset();
    spawn(15, 0, 1);
    spawn(0, 7, 6);
    run_pass(1'b0);

    // 4: full store refuses a fifth shot
    do_reset();
    spawn(2, 2, 0);
    spawn(3, 3, 1);
    spawn(4, 4, 2);
    spawn(8, 8, 3);
    spawn(9, 9, 4);
    tick();
    chk("desc_one_cycle", 32'(td0), 0);
    check_dut(0, mk_snap(0));
    check_dut(1, mk_snap(1));

    // 5: iniciar wins; novo_tiro during pass ignored
    do_reset();
    novo_x = 4'd7;
    novo_y = 4'd7;
    nova_direcao = 3'd4;
    run_pass(1'b1);

    // 6: reset in the middle of a pass
    do_reset();
    spawn(5, 5, 2);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_db", 32'(db0), 2);
    reset = 1'b0;
    model_clear();
    #1;
    check_reset_vals("mid");
    sel = 2'd0;
    #1;
    chk("mid_x0", 32'(x0), 0);
    tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cc0 || cc1) seen = 1;
    end
    chk("no_conc", 32'(seen), 0);
    spawn(3, 3, 4);
    run_pass(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
